// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone classic round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic {IDLE, GRANTED} arb_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first asserted request after last_idx, with wrap.
module wb_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_idx,
  output logic             any,
  output logic [IW-1:0]    next_idx
);

  // Scan farthest offset first so the nearest requester after last_idx wins.
  always_comb begin
    int          cand;
    logic [IW-1:0] cand_idx;
    any      = 1'b0;
    next_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = int'(last_idx) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IW'(cand);
      if (req[cand_idx]) begin
        any      = 1'b1;
        next_idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/wishbone_classic_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic device between N_REQ controllers.
// Optional stall timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_classic_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DAT_WIDTH      = 8,
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_REQ-1:0]           req_cyc_i,
  input  logic [N_REQ-1:0]           req_stb_i,
  input  logic [N_REQ-1:0]           req_we_i,
  input  logic [N_REQ*DAT_WIDTH-1:0] req_dat_i,
  output logic [N_REQ-1:0]           req_ack_o,
  output logic [N_REQ-1:0]           req_err_o,
  output logic [N_REQ-1:0]           req_rty_o,
  output logic                       cyc_o,
  output logic                       stb_o,
  output logic                       we_o,
  output logic [DAT_WIDTH-1:0]       dat_o,
  input  logic                       ack_i,
  input  logic                       err_i,
  input  logic                       rty_i,
  output logic [N_REQ-1:0]           grant_o
);

  localparam int IW = idx_width(N_REQ);

  arb_state_t    state, state_next;
  logic [IW-1:0] grant_idx, last_idx, pick_idx;
  logic          pick_any;
  logic          timeout_hit;

  wb_rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req      (req_cyc_i),
    .last_idx (last_idx),
    .any      (pick_any),
    .next_idx (pick_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      grant_idx <= '0;
      last_idx  <= IW'(N_REQ - 1);
    end else begin
      state <= state_next;
      if (state == IDLE && pick_any) begin
        grant_idx <= pick_idx;
        last_idx  <= pick_idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_any) state_next = GRANTED;
      GRANTED: if (!req_cyc_i[grant_idx]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Device side follows the granted requester; responses go back to it alone.
  always_comb begin
    cyc_o     = 1'b0;
    stb_o     = 1'b0;
    we_o      = 1'b0;
    dat_o     = '0;
    req_ack_o = '0;
    req_err_o = '0;
    req_rty_o = '0;
    grant_o   = '0;
    if (state == GRANTED) begin
      cyc_o                = req_cyc_i[grant_idx];
      stb_o                = req_stb_i[grant_idx] & ~timeout_hit;
      we_o                 = req_we_i[grant_idx];
      dat_o                = req_dat_i[int'(grant_idx)*DAT_WIDTH +: DAT_WIDTH];
      req_ack_o[grant_idx] = ack_i;
      req_err_o[grant_idx] = err_i | timeout_hit;
      req_rty_o[grant_idx] = rty_i;
      grant_o[grant_idx]   = 1'b1;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 32) ? 32 : TW_RAW);

  logic [TW-1:0] stall_cnt;
  logic          any_resp;

  assign any_resp    = ack_i | err_i | rty_i;
  assign timeout_hit = (state == GRANTED) && (stall_cnt == TW'(TIMEOUT_CYCLES));

  // Holding the counter at zero outside GRANTED gives a fresh count on every new grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (state != GRANTED || any_resp || timeout_hit) begin
      stall_cnt <= '0;
    end else if (req_stb_i[grant_idx]) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  // Timeout compiled out; the parameter stays for a uniform interface and is always >= 1.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_wishbone_classic_arbiter.sv
// Self-checking bench for wishbone_classic_arbiter: directed scenarios then random traffic
// against a transaction-level round-robin model. Honours WB_ARB_TIMEOUT_EN if defined.
module tb_wishbone_classic_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int TO = 5;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [NR-1:0]    req_cyc, req_stb, req_we;
  logic [DW-1:0]    req_dat [NR];
  logic [NR*DW-1:0] req_dat_flat;
  logic [NR-1:0]    req_ack, req_err, req_rty, grant;
  logic             cyc_o, stb_o, we_o;
  logic [DW-1:0]    dat_o;
  logic             ack_i, err_i, rty_i;

  int compared   = 0;
  int mismatched = 0;

  // Model: owner = granted requester (-1 when idle), last_owner = most recent grant.
  int owner      = -1;
  int last_owner = NR - 1;
  int stall      = 0;
  logic [NR-1:0] obs_ack, obs_err;

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int i = 0; i < NR; i++) req_dat_flat[i*DW +: DW] = req_dat[i];
  end

  wishbone_classic_arbiter #(
    .DAT_WIDTH      (DW),
    .N_REQ          (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_cyc_i (req_cyc),
    .req_stb_i (req_stb),
    .req_we_i  (req_we),
    .req_dat_i (req_dat_flat),
    .req_ack_o (req_ack),
    .req_err_o (req_err),
    .req_rty_o (req_rty),
    .cyc_o     (cyc_o),
    .stb_o     (stb_o),
    .we_o      (we_o),
    .dat_o     (dat_o),
    .ack_i     (ack_i),
    .err_i     (err_i),
    .rty_i     (rty_i),
    .grant_o   (grant)
  );

  function automatic int pickNext();
    for (int k = 1; k <= NR; k++) begin
      int c;
      c = (last_owner + k) % NR;
      if (req_cyc[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit timeoutHit();
`ifdef WB_ARB_TIMEOUT_EN
    return (owner >= 0) && (stall == TO);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [NR-1:0] e_grant, e_ack, e_err, e_rty;
    logic          e_cyc, e_stb, e_we;
    logic [DW-1:0] e_dat;
    bit            hit;
    hit     = timeoutHit();
    e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0;
    e_cyc   = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_dat = '0;
    if (owner >= 0) begin
      e_grant[owner] = 1'b1;
      e_cyc          = req_cyc[owner];
      e_stb          = req_stb[owner] && !hit;
      e_we           = req_we[owner];
      e_dat          = req_dat[owner];
      e_ack[owner]   = ack_i;
      e_err[owner]   = err_i || hit;
      e_rty[owner]   = rty_i;
    end
    check("grant", 32'(grant), 32'(e_grant));
    check("cyc",   32'(cyc_o), 32'(e_cyc));
    check("stb",   32'(stb_o), 32'(e_stb));
    check("we",    32'(we_o),  32'(e_we));
    check("dat",   32'(dat_o), 32'(e_dat));
    check("ack",   32'(req_ack), 32'(e_ack));
    check("err",   32'(req_err), 32'(e_err));
    check("rty",   32'(req_rty), 32'(e_rty));
    obs_ack = req_ack;
    obs_err = req_err;
  endtask

  // Advance the model by one clock edge from the inputs seen during the cycle.
  task automatic modelEdge();
    bit hit;
    hit = timeoutHit();
    if (owner < 0) begin
      int n;
      n = pickNext();
      if (n >= 0) begin
        owner      = n;
        last_owner = n;
        stall      = 0;
      end
    end else if (!req_cyc[owner]) begin
      owner = -1;
      stall = 0;
    end else if (ack_i || err_i || rty_i || hit) begin
      stall = 0;
    end else if (req_stb[owner]) begin
      stall++;
    end
  endtask

  task automatic step();
    #4;
    checkOutput();
    @(posedge clk_i);
    if (rst_ni) modelEdge();
    #1;
  endtask

  task automatic applyStimulus(input logic [NR-1:0] c, input logic [NR-1:0] s,
                               input logic [NR-1:0] w, input logic a,
                               input logic e, input logic r);
    req_cyc = c; req_stb = s; req_we = w;
    ack_i = a; err_i = e; rty_i = r;
    for (int i = 0; i < NR; i++) req_dat[i] = DW'($urandom);
    step();
  endtask

  task automatic applyReset();
    rst_ni  = 1'b0;
    req_cyc = '0; req_stb = '0; req_we = '0;
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
    for (int i = 0; i < NR; i++) req_dat[i] = '0;
    owner = -1; last_owner = NR - 1; stall = 0;
    #3;
    checkOutput();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int ack_seen;
    int err_seen;
    logic [NR-1:0] reqs;

    // Reset state
    applyReset();

    // Single requester, three acked transfers in one CYC
    ack_seen = 0;
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 0, 0, 0);
    check("t1_grant", 32'(grant), 32'h1);
    for (int t = 0; t < 3; t++) begin
      applyStimulus(4'b0001, 4'b0001, 4'b0001, 0, 0, 0);
      ack_seen += int'(obs_ack[0]);
      applyStimulus(4'b0001, 4'b0001, 4'b0001, 1, 0, 0);
      ack_seen += int'(obs_ack[0]);
    end
    check("t1_acks", 32'(ack_seen), 32'd3);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    check("t1_release", 32'(grant), 32'h0);

    // Three simultaneous requesters after reset: 0, 1, 2 with idle cycles between
    applyReset();
    reqs = 4'b0111;
    applyStimulus(reqs, 4'b0000, 4'b0000, 0, 0, 0);
    check("t2_grant0", 32'(grant), 32'h1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(reqs, reqs, 4'b0000, 1, 0, 0);
      reqs[k] = 1'b0;
      applyStimulus(reqs, reqs, 4'b0000, 0, 0, 0);
      check("t2_idle", 32'(grant), 32'h0);
      if (k < 2) begin
        applyStimulus(reqs, 4'b0000, 4'b0000, 0, 0, 0);
        check("t2_next", 32'(grant), 32'(1 << (k + 1)));
      end
    end

    // Error goes only to the owner; waiting requester 1 sees nothing
    applyStimulus(4'b0011, 4'b0011, 4'b0000, 0, 0, 0);
    check("t3_grant", 32'(grant), 32'h1);
    applyStimulus(4'b0011, 4'b0011, 4'b0000, 0, 1, 0);
    check("t3_err", 32'(obs_err), 32'h1);
    applyStimulus(4'b0010, 4'b0010, 4'b0000, 0, 0, 0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);

    // Async reset mid-transfer, then re-arbitration from requester 0
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 0, 0, 0);
    req_cyc = 4'b0001; req_stb = 4'b0001;
    #2 rst_ni = 1'b0;
    #1;
    check("t4_cyc", 32'(cyc_o), 32'h0);
    check("t4_stb", 32'(stb_o), 32'h0);
    check("t4_grant", 32'(grant), 32'h0);
    owner = -1; last_owner = NR - 1; stall = 0;
    @(posedge clk_i);
    #1;
    req_cyc = 4'b1111; req_stb = 4'b0000;
    #2 rst_ni = 1'b1;
    step();
    check("t4_regrant", 32'(grant), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 0, 0, 0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    // last=1 with requests 0 and 3 must grant 3
    applyStimulus(4'b1001, 4'b0000, 4'b0000, 0, 0, 0);
    check("rr_example", 32'(grant), 32'h8);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);

    // Requester 2 drops and re-raises CYC while 3 waits
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 0, 0, 0);
    check("t6_grant2", 32'(grant), 32'h4);
    applyStimulus(4'b1100, 4'b0100, 4'b0000, 1, 0, 0);
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 0, 0, 0);
    applyStimulus(4'b1100, 4'b0000, 4'b0000, 0, 0, 0);
    check("t6_grant3", 32'(grant), 32'h8);
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 0, 0, 0);
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 0, 0, 0);
    check("t6_regain2", 32'(grant), 32'h4);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);

    // Stalled device: one forced error after TO stalled cycles when the timeout is built in
    err_seen = 0;
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 0, 0, 0);
    for (int t = 0; t < TO + 3; t++) begin
      applyStimulus(4'b0001, 4'b0001, 4'b0000, 0, 0, 0);
      err_seen += int'(obs_err[0]);
    end
    check("to_grant_held", 32'(grant), 32'h1);
`ifdef WB_ARB_TIMEOUT_EN
    check("to_err_pulses", 32'(err_seen), 32'd1);
`else
    check("to_err_pulses", 32'(err_seen), 32'd0);
`endif
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);

    // Random traffic against the model
    reqs = '0;
    for (int t = 0; t < 400; t++) begin
      int r;
      for (int i = 0; i < NR; i++) if ($urandom_range(0, 7) == 0) reqs[i] = ~reqs[i];
      r = int'($urandom_range(0, 7));
      applyStimulus(reqs, NR'($urandom), NR'($urandom), r == 0, r == 1, r == 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
